stepper_move_sequencer: RTL and testbench
=========================================

Name: stepper_move_sequencer

Overview:
- Sits between the processor's memory-mapped motor command path and the PMOD coil pins JB1..JB4.
- Accepts "move N steps in direction D" commands over a valid/ready handshake.
- Paces steps with an internal clock-enable divider, so it needs no derived clock.
- Drives the 4-phase full-step coil pattern, tracks absolute position, and reports busy/done to software.

Parameters:
- CLK_DIV, 160000, clk cycles per step (100 MHz / 625 Hz); legal values ≥ 2.
- STEP_W, 16, width of the step-count command.
- POS_W, 16, width of the signed absolute position counter.
- HOLD, 0, 1 = keep coils energised when idle; 0 = drive coils 0000 when idle.

Ports:
- clk  in  1  system clock (CLK100MHZ domain).
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_dir  in  1  1 = forward (+1 per step), 0 = reverse (−1 per step).
- cmd_steps  in  STEP_W  number of steps to take (unsigned).
- abort  in  1  stop the current move at the next clock edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a move completes or is aborted.
- position  out  POS_W  signed absolute step count.
- coils  out  4  {jb1, jb2, jb3, jb4} coil drive.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, phase index=0, position=0, remaining=0, tick counter=0, busy=0, done=0, coils=0000. cmd_ready is 1 from the first cycle after reset deasserts.
- cmd_ready = (state==IDLE) && !abort && !reset. It is combinational.
- Acceptance: a command is accepted on a clk edge where cmd_valid && cmd_ready.
  - Latch dir, load remaining=cmd_steps, clear the tick counter.
  - If cmd_steps≠0, go to RUN.
  - If cmd_steps==0, stay IDLE and pulse done on the next cycle. No step, no position change.
- RUN:
  - The tick counter counts 0..CLK_DIV−1. A step fires on the cycle the counter equals CLK_DIV−1; the counter then wraps to 0.
  - So the first step occurs CLK_DIV cycles after acceptance, and each later step follows CLK_DIV cycles after the previous one.
- On each step:
  - phase index ±1 mod 4 (forward increments, reverse decrements).
  - position ±1, with two's-complement wrap at POS_W.
  - remaining −1.
- If remaining reaches 0 on a step: registered done=1 for exactly one cycle, go to IDLE. cmd_ready rises in that same cycle.
- Coil pattern by phase index: 0→1100, 1→0110, 2→0011, 3→1001. coils are registered and update on the step edge.
- Idle coils: HOLD=1 keeps the last pattern. HOLD=0 drives 0000 in IDLE. The phase index is retained either way, so the next move resumes electrically continuous.
- Abort:
  - abort during RUN: the next edge goes to IDLE, clears remaining, pulses done. No step is taken on that edge, even if a tick coincides; abort has priority. position reflects only steps actually taken.
  - abort in IDLE: no effect except that it forces cmd_ready low, so no command is accepted that cycle.
- busy = (state==RUN). It is registered, so it rises on the cycle after acceptance.
- cmd_valid while busy is ignored; there is no queueing. Software must wait for cmd_ready.
- Reset mid-move: immediate return to the reset values on the next edge. Position is lost.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package (stepper_pkg):
  - state encoding: IDLE=2'd0, RUN=2'd1.
  - the 4-entry full-step coil table constant.
  - DEFAULT_CLK_DIV=160000.
- One natural sub-module: step_tick_gen. It is a resettable modulo-CLK_DIV counter with enable and synchronous clear, emitting a one-cycle tick. It replaces a derived clock and is reusable by other pacing logic.

Test Plan (CLK_DIV=4, STEP_W=8, POS_W=8, HOLD=0 unless stated):
1. Reset then idle → coils=0000, position=0, busy=0, cmd_ready=1, done=0 for 20 cycles.
2. Accept dir=1, steps=3 at cycle T.
   - busy=1 at T+1.
   - coils 0110 at T+4, 0011 at T+8, 1001 at T+12.
   - done pulse one cycle after T+12; position=3.
   - coils=0000 after done.
3. Then dir=0, steps=5.
   - Phase sequence 0011,0110,1100,1001,0011 at 4-cycle spacing.
   - position=−2 (8'hFE); exactly one done pulse.
4. steps=0 → done one cycle after accept, busy stays 0, position and coils unchanged. cmd_valid held during a RUN is never accepted (cmd_ready=0).
5. Start steps=10, assert abort on the same cycle as the 2nd tick.
   - No step on that edge; position=+1; done pulses once; back in IDLE.
   - abort+cmd_valid together in IDLE → not accepted.
6. HOLD=1, from position 0: steps=2 forward → coils hold at 0011 in IDLE. Assert reset mid-move of a new command → next edge coils=0000, position=0, busy=0.

Source files
------------

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types and constants for the stepper move sequencer
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  // Full-step coil drive {jb1, jb2, jb3, jb4} indexed by phase 0..3
  localparam logic [3:0][3:0] COIL_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

  localparam int DEFAULT_CLK_DIV = 160000;

endpackage

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - modulo-DIV clock-enable counter emitting a one-cycle tick
module step_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is only meaningful while counting; it marks the last count of the period
  assign tick = en && (cnt == LAST);

  // Counter: clear wins over enable, wrap to 0 after the last count
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stepper_move_sequencer.sv
// rtl/stepper_move_sequencer.sv - paced N-step moves with 4-phase full-step coil drive
module stepper_move_sequencer
  import stepper_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int STEP_W  = 16,
  parameter int POS_W   = 16,
  parameter int HOLD    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position,
  output logic [3:0]        coils
);

  state_t              state, state_n;
  logic [STEP_W-1:0]   remaining, remaining_n;
  logic                dir_q, dir_n;
  logic [1:0]          phase, phase_n;
  logic                done_n;
  logic                step;
  logic                tick;
  logic                tick_clr;
  logic                accept;

  // Ready only in IDLE; abort and reset both block acceptance combinationally
  assign cmd_ready = (state == IDLE) && !abort && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign phase_n   = dir_q ? (phase + 2'd1) : (phase - 2'd1);

  step_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Next-state: acceptance, stepping, completion and abort (abort beats a coincident tick)
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_n       = dir_q;
    done_n      = 1'b0;
    step        = 1'b0;
    tick_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          dir_n       = cmd_dir;
          remaining_n = cmd_steps;
          tick_clr    = 1'b1;
          if (cmd_steps != '0) begin
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n     = IDLE;
          remaining_n = '0;
          done_n      = 1'b1;
          tick_clr    = 1'b1;
        end else if (tick) begin
          step        = 1'b1;
          remaining_n = remaining - STEP_W'(1);
          if (remaining == STEP_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register plus move bookkeeping and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir_q     <= dir_n;
      done      <= done_n;
      busy      <= (state_n == RUN);
    end
  end

  // Phase, position and coil drive; phase survives idle so moves resume continuously
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 2'd0;
      position <= '0;
      coils    <= 4'b0000;
    end else if (step) begin
      phase    <= phase_n;
      position <= dir_q ? (position + POS_W'(1)) : (position - POS_W'(1));
      coils    <= COIL_TABLE[phase_n];
    end else if ((state == IDLE) && (HOLD == 0)) begin
      coils    <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// tb/tb_stepper_move_sequencer.sv - directed self-checking bench for stepper_move_sequencer
module tb_stepper_move_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cmd_valid, cmd_ready, cmd_dir, abort, busy, done;
  logic [7:0] cmd_steps, position;
  logic [3:0] coils;

  logic       h_reset, h_cmd_valid, h_cmd_ready, h_cmd_dir, h_abort, h_busy, h_done;
  logic [7:0] h_cmd_steps, h_position;
  logic [3:0] h_coils;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  stepper_move_sequencer #(.CLK_DIV(4), .STEP_W(8), .POS_W(8), .HOLD(0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort), .busy(busy),
    .done(done), .position(position), .coils(coils)
  );

  stepper_move_sequencer #(.CLK_DIV(4), .STEP_W(8), .POS_W(8), .HOLD(1)) dut_hold (
    .clk(clk), .reset(h_reset), .cmd_valid(h_cmd_valid), .cmd_ready(h_cmd_ready),
    .cmd_dir(h_cmd_dir), .cmd_steps(h_cmd_steps), .abort(h_abort), .busy(h_busy),
    .done(h_done), .position(h_position), .coils(h_coils)
  );

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
  endtask

  task automatic accept(input logic d, input logic [7:0] s);
    cmd_dir   = d;
    cmd_steps = s;
    cmd_valid = 1'b1;
    adv(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 20; i++) begin
      adv(1);
      total++; if (coils !== 4'b0000) begin bad++; $display("FAIL reset_coils cyc=%0d got=%b want=0000", i, coils); end
      total++; if (position !== 8'h00) begin bad++; $display("FAIL reset_position cyc=%0d got=%h want=00", i, position); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", i, busy); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b want=1", i, cmd_ready); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done cyc=%0d got=%b want=0", i, done); end
    end
  endtask

  task automatic test_forward;
    done_cnt = 0;
    accept(1'b1, 8'd3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fwd_busy_k0 got=%b want=1", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fwd_ready_k0 got=%b want=0", cmd_ready); end
    adv(3);
    total++; if (coils !== 4'b0000) begin bad++; $display("FAIL fwd_coils_k3 got=%b want=0000", coils); end
    adv(1);
    total++; if (coils !== 4'b0110) begin bad++; $display("FAIL fwd_coils_k4 got=%b want=0110", coils); end
    total++; if (position !== 8'd1) begin bad++; $display("FAIL fwd_pos_k4 got=%h want=01", position); end
    adv(4);
    total++; if (coils !== 4'b0011) begin bad++; $display("FAIL fwd_coils_k8 got=%b want=0011", coils); end
    adv(3);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fwd_k11 got done=%b busy=%b want done=0 busy=1", done, busy); end
    adv(1);
    total++; if (coils !== 4'b1001) begin bad++; $display("FAIL fwd_coils_k12 got=%b want=1001", coils); end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL fwd_done_k12 got done=%b busy=%b want done=1 busy=0", done, busy); end
    total++; if (position !== 8'd3) begin bad++; $display("FAIL fwd_pos_k12 got=%h want=03", position); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready_k12 got=%b want=1", cmd_ready); end
    adv(1);
    total++; if (done !== 1'b0 || coils !== 4'b0000) begin bad++; $display("FAIL fwd_k13 got done=%b coils=%b want done=0 coils=0000", done, coils); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL fwd_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reverse;
    logic [3:0] exp_coils [5];
    exp_coils = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
    done_cnt = 0;
    accept(1'b0, 8'd5);
    for (int i = 0; i < 5; i++) begin
      adv(4);
      total++; if (coils !== exp_coils[i]) begin bad++; $display("FAIL rev_coils step=%0d got=%b want=%b", i, coils, exp_coils[i]); end
      total++; if (done !== (i == 4)) begin bad++; $display("FAIL rev_done step=%0d got=%b want=%b", i, done, (i == 4)); end
    end
    adv(1);
    total++; if (position !== 8'hFE) begin bad++; $display("FAIL rev_pos got=%h want=fe", position); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rev_done_count got=%0d want=1", done_cnt); end
    total++; if (coils !== 4'b0000) begin bad++; $display("FAIL rev_idle_coils got=%b want=0000", coils); end
  endtask

  task automatic test_zero_and_busy_ignore;
    done_cnt = 0;
    accept(1'b0, 8'd0);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_k0 got done=%b busy=%b want done=1 busy=0", done, busy); end
    total++; if (position !== 8'hFE || coils !== 4'b0000) begin bad++; $display("FAIL zero_state got pos=%h coils=%b want pos=fe coils=0000", position, coils); end
    adv(1);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_k1 got done=%b busy=%b want done=0 busy=0", done, busy); end
    accept(1'b1, 8'd1);
    cmd_steps = 8'd7;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_ready k=%0d got=%b want=0", i, cmd_ready); end
      adv(1);
    end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_ready k=3 got=%b want=0", cmd_ready); end
    cmd_valid = 1'b0;
    adv(1);
    total++; if (done !== 1'b1 || position !== 8'hFF) begin bad++; $display("FAIL busy_end got done=%b pos=%h want done=1 pos=ff", done, position); end
    adv(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_not_queued got=%b want=0", busy); end
    total++; if (done_cnt !== 2) begin bad++; $display("FAIL zero_done_count got=%0d want=2", done_cnt); end
  endtask

  task automatic test_abort;
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    total++; if (position !== 8'h00 || coils !== 4'b0000) begin bad++; $display("FAIL abort_prereset got pos=%h coils=%b want 00/0000", position, coils); end
    done_cnt = 0;
    accept(1'b1, 8'd10);
    adv(4);
    total++; if (position !== 8'd1 || coils !== 4'b0110) begin bad++; $display("FAIL abort_k4 got pos=%h coils=%b want 01/0110", position, coils); end
    adv(3);
    abort = 1'b1;
    adv(1);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_k8 got done=%b busy=%b want done=1 busy=0", done, busy); end
    total++; if (position !== 8'd1 || coils !== 4'b0110) begin bad++; $display("FAIL abort_nostep got pos=%h coils=%b want 01/0110", position, coils); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_blocked got=%b want=0", cmd_ready); end
    abort = 1'b0;
    adv(1);
    total++; if (done !== 1'b0 || coils !== 4'b0000 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_k9 got done=%b coils=%b ready=%b want 0/0000/1", done, coils, cmd_ready); end
    adv(8);
    total++; if (position !== 8'd1 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got pos=%h busy=%b want 01/0", position, busy); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_count got=%0d want=1", done_cnt); end
    abort = 1'b1;
    cmd_dir = 1'b1;
    cmd_steps = 8'd3;
    cmd_valid = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL idle_abort_ready got=%b want=0", cmd_ready); end
    adv(1);
    abort = 1'b0;
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_abort_accept got busy=%b done=%b want 0/0", busy, done); end
    adv(5);
    total++; if (position !== 8'd1 || busy !== 1'b0) begin bad++; $display("FAIL idle_abort_after got pos=%h busy=%b want 01/0", position, busy); end
  endtask

  task automatic test_hold_and_reset;
    h_cmd_dir = 1'b1;
    h_cmd_steps = 8'd2;
    h_cmd_valid = 1'b1;
    adv(1);
    h_cmd_valid = 1'b0;
    adv(8);
    total++; if (h_done !== 1'b1 || h_coils !== 4'b0011 || h_position !== 8'd2) begin bad++; $display("FAIL hold_end got done=%b coils=%b pos=%h want 1/0011/02", h_done, h_coils, h_position); end
    adv(5);
    total++; if (h_coils !== 4'b0011 || h_busy !== 1'b0) begin bad++; $display("FAIL hold_idle got coils=%b busy=%b want 0011/0", h_coils, h_busy); end
    h_cmd_steps = 8'd3;
    h_cmd_valid = 1'b1;
    adv(1);
    h_cmd_valid = 1'b0;
    adv(4);
    total++; if (h_coils !== 4'b1001 || h_position !== 8'd3 || h_busy !== 1'b1) begin bad++; $display("FAIL hold_move2 got coils=%b pos=%h busy=%b want 1001/03/1", h_coils, h_position, h_busy); end
    adv(1);
    h_reset = 1'b1;
    adv(1);
    total++; if (h_coils !== 4'b0000 || h_position !== 8'd0) begin bad++; $display("FAIL midreset_state got coils=%b pos=%h want 0000/00", h_coils, h_position); end
    total++; if (h_busy !== 1'b0 || h_done !== 1'b0 || h_cmd_ready !== 1'b0) begin bad++; $display("FAIL midreset_flags got busy=%b done=%b ready=%b want 0/0/0", h_busy, h_done, h_cmd_ready); end
    h_reset = 1'b0;
    #1;
    total++; if (h_cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", h_cmd_ready); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 8'd0; abort = 1'b0;
    h_reset = 1'b1; h_cmd_valid = 1'b0; h_cmd_dir = 1'b0; h_cmd_steps = 8'd0; h_abort = 1'b0;
    adv(2);
    reset = 1'b0;
    h_reset = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_zero_and_busy_ignore();
    test_abort();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
